// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM responder: checks the power-up/init sequence, tracks open banks and
// serves single-word READ/WRITE from an internal array with the programmed CAS latency.
module sdram_cmd_responder #(
  parameter int unsigned PWR_CYCLES = 10000,
  parameter int unsigned REF_MIN    = 2,
  parameter int unsigned TMRD       = 2,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic        iclk,
  input  logic        ctr_reset,
  input  logic        DRAM_CKE,
  input  logic        DRAM_CS_N,
  input  logic        DRAM_RAS_N,
  input  logic        DRAM_CAS_N,
  input  logic        DRAM_WE_N,
  input  logic [12:0] DRAM_ADDR,
  input  logic [1:0]  DRAM_BA,
  input  logic        DRAM_UDQM,
  input  logic        DRAM_LDQM,
  input  logic [15:0] idq,
  output logic [15:0] odq,
  output logic [1:0]  odq_oe,
  output logic        oinit_done,
  output logic [12:0] omode,
  output logic        oerr,
  output logic [2:0]  oerr_code
);
  localparam int unsigned PCW = $clog2(PWR_CYCLES + 1);
  localparam int unsigned RCW = $clog2(REF_MIN + 1);
  localparam int unsigned MCW = $clog2(TMRD + 1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_BT  = 4'b0110;

  typedef enum logic [1:0] {PWR_WAIT, PRE_DONE, MRD_WAIT, READY} state_e;

  state_e            state_q, state_d;
  logic [PCW-1:0]    pwr_cnt_q, pwr_cnt_d;
  logic [RCW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [MCW-1:0]    mrd_cnt_q, mrd_cnt_d;
  logic [3:0]        open_q, open_d;
  logic [12:0]       mode_q, mode_d;
  logic              err_q, done_q;
  logic [2:0]        code_q;
  logic              err_c, rd_c, wr_c, idle_c, cas_bad_c, cl3_c;
  logic [2:0]        code_c;
  logic [3:0]        cmd_c;
  logic [MEM_AW-1:0] idx_c;
  logic [15:0]       rd_data_c;
  logic [15:0]       mem [0:(1 << MEM_AW) - 1];
  logic [2:0]        pv_q;
  logic [2:0][15:0]  pdq_q;
  logic [2:0][1:0]   poe_q;
  logic [15:0]       odq_q;
  logic [1:0]        odq_oe_q;

  // Chip-select high and BURST TERM both decode to an idle cycle
  assign cmd_c     = DRAM_CS_N ? CMD_NOP : {1'b0, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
  assign idle_c    = (cmd_c == CMD_NOP) || (cmd_c == CMD_BT);
  assign idx_c     = {DRAM_BA, DRAM_ADDR[MEM_AW-3:0]};
  assign cas_bad_c = (DRAM_ADDR[6:4] != 3'd2) && (DRAM_ADDR[6:4] != 3'd3);
  assign cl3_c     = (mode_q[6:4] == 3'd3);
  assign rd_data_c = mem[idx_c];

  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    ref_cnt_d = ref_cnt_q;
    mrd_cnt_d = mrd_cnt_q;
    open_d    = open_q;
    mode_d    = mode_q;
    err_c     = 1'b0;
    code_c    = 3'd0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    if (DRAM_CKE) begin
      unique case (state_q)
        PWR_WAIT: begin
          if (idle_c) begin
            if (pwr_cnt_q != PCW'(PWR_CYCLES)) pwr_cnt_d = pwr_cnt_q + PCW'(1);
          end else if ((cmd_c == CMD_PRE) && DRAM_ADDR[10] && (pwr_cnt_q >= PCW'(PWR_CYCLES))) begin
            state_d   = PRE_DONE;
            ref_cnt_d = '0;
          end else begin
            err_c  = 1'b1;
            code_c = 3'd1;
          end
        end
        PRE_DONE: begin
          case (cmd_c)
            CMD_REF: if (ref_cnt_q != RCW'(REF_MIN)) ref_cnt_d = ref_cnt_q + RCW'(1);
            CMD_LMR: begin
              mode_d    = DRAM_ADDR;
              state_d   = MRD_WAIT;
              mrd_cnt_d = '0;
              if (ref_cnt_q < RCW'(REF_MIN)) begin
                err_c  = 1'b1;
                code_c = 3'd2;
              end else if (cas_bad_c) begin
                err_c  = 1'b1;
                code_c = 3'd5;
              end
            end
            CMD_ACT, CMD_RD, CMD_WR: begin
              err_c  = 1'b1;
              code_c = 3'd2;
            end
            default: ;
          endcase
        end
        MRD_WAIT: begin
          if (!idle_c) begin
            err_c  = 1'b1;
            code_c = 3'd3;
          end
          if (mrd_cnt_q == MCW'(TMRD - 1)) state_d = READY;
          else mrd_cnt_d = mrd_cnt_q + MCW'(1);
        end
        READY: begin
          case (cmd_c)
            CMD_ACT: begin
              if (open_q[DRAM_BA]) begin
                err_c  = 1'b1;
                code_c = 3'd6;
              end
              open_d[DRAM_BA] = 1'b1;
            end
            CMD_RD, CMD_WR: begin
              if (!open_q[DRAM_BA]) begin
                err_c  = 1'b1;
                code_c = 3'd7;
              end else begin
                rd_c = (cmd_c == CMD_RD);
                wr_c = (cmd_c == CMD_WR);
              end
            end
            CMD_PRE: begin
              if (DRAM_ADDR[10]) open_d = '0;
              else open_d[DRAM_BA] = 1'b0;
            end
            CMD_REF: begin
              if (|open_q) begin
                err_c  = 1'b1;
                code_c = 3'd4;
              end
            end
            CMD_LMR: begin
              if (|open_q) begin
                err_c  = 1'b1;
                code_c = 3'd4;
              end else begin
                mode_d = DRAM_ADDR;
                if (cas_bad_c) begin
                  err_c  = 1'b1;
                  code_c = 3'd5;
                end
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state_q   <= PWR_WAIT;
      pwr_cnt_q <= '0;
      ref_cnt_q <= '0;
      mrd_cnt_q <= '0;
      open_q    <= '0;
      mode_q    <= '0;
      err_q     <= 1'b0;
      code_q    <= 3'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_cnt_q <= pwr_cnt_d;
      ref_cnt_q <= ref_cnt_d;
      mrd_cnt_q <= mrd_cnt_d;
      open_q    <= open_d;
      mode_q    <= mode_d;
      done_q    <= (state_q == READY);
      if (err_c && !err_q) begin
        err_q  <= 1'b1;
        code_q <= code_c;
      end
    end
  end

  // Read pipeline: a READ enters at slot CL-1 and reaches the output register CL cycles later
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      pv_q     <= '0;
      pdq_q    <= '0;
      poe_q    <= '0;
      odq_q    <= '0;
      odq_oe_q <= '0;
    end else begin
      pv_q  <= {1'b0, pv_q[2:1]};
      pdq_q <= {16'h0000, pdq_q[2:1]};
      poe_q <= {2'b00, poe_q[2:1]};
      if (rd_c) begin
        if (cl3_c) begin
          pv_q[2]  <= 1'b1;
          pdq_q[2] <= rd_data_c;
          poe_q[2] <= ~{DRAM_UDQM, DRAM_LDQM};
        end else begin
          pv_q[1]  <= 1'b1;
          pdq_q[1] <= rd_data_c;
          poe_q[1] <= ~{DRAM_UDQM, DRAM_LDQM};
        end
      end
      odq_q    <= pv_q[0] ? pdq_q[0] : 16'h0000;
      odq_oe_q <= pv_q[0] ? poe_q[0] : 2'b00;
    end
  end

  // Storage array, byte-masked writes, not reset
  always_ff @(posedge iclk) begin
    if (wr_c) begin
      if (!DRAM_LDQM) mem[idx_c][7:0]  <= idq[7:0];
      if (!DRAM_UDQM) mem[idx_c][15:8] <= idq[15:8];
    end
  end

  assign odq        = odq_q;
  assign odq_oe     = odq_oe_q;
  assign oinit_done = done_q;
  assign omode      = mode_q;
  assign oerr       = err_q;
  assign oerr_code  = code_q;

endmodule
